// File: rtl/bunch_strb_seq_pkg.sv
// Shared types and default widths for the bunch strobe sequencer.
// The optional missed-trigger counter is built when BUNCH_STRB_SEQ_MISS_CNT_EN is defined.
package bunch_strb_seq_pkg;

    localparam int DEF_DLY_W    = 8;
    localparam int DEF_LEN_W    = 7;
    localparam int DEF_HOLD_CYC = 4;
    localparam int MISS_CNT_W   = 16;

    typedef enum logic [2:0] {
        INIT_CLR = 3'd0,
        IDLE     = 3'd1,
        DELAY    = 3'd2,
        INTEG    = 3'd3,
        WAIT1    = 3'd4,
        HOLD     = 3'd5,
        CLEAR    = 3'd6
    } state_t;

endpackage

// File: rtl/bss_dncnt.sv
// Loadable down-counter that stops at zero; flags report zero and one-remaining.
module bss_dncnt
    import bunch_strb_seq_pkg::*;
#(
    parameter int W = DEF_DLY_W
) (
    input  logic         clk,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= d;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign last = (cnt == W'(1));

endmodule

// File: rtl/bunch_strb_seq.sv
// Trigger-to-integration-window sequencer driving bunch_strb, mux select and integrator clear.
// Define BUNCH_STRB_SEQ_MISS_CNT_EN to add the saturating missed_trig counter output.
module bunch_strb_seq
    import bunch_strb_seq_pkg::*;
#(
    parameter int DLY_W    = DEF_DLY_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic [DLY_W-1:0] strb_start,
    input  logic [LEN_W-1:0] strb_len,
    input  logic [1:0]       sel_in,
    output logic [1:0]       sel,
    output logic             bunch_strb,
    output logic             dac_cond,
    output logic             int_valid,
    output logic             busy
`ifdef BUNCH_STRB_SEQ_MISS_CNT_EN
    ,
    output logic [MISS_CNT_W-1:0] missed_trig
`endif
);

    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              dly_zero;
    logic              dly_last;
    logic              len_zero;
    logic              len_last;
    logic [HOLD_W-1:0] hold_cnt;
    logic              bs_d;
    logic              dac_d;
    logic              iv_d;
    logic              busy_d;

    assign accept = (state_q == IDLE) && trig;

    bss_dncnt #(.W(DLY_W)) u_dly (
        .clk  (clk),
        .load (accept),
        .en   (state_q == DELAY),
        .d    (strb_start),
        .zero (dly_zero),
        .last (dly_last)
    );

    bss_dncnt #(.W(LEN_W)) u_len (
        .clk  (clk),
        .load (accept),
        .en   (state_q == INTEG),
        .d    (strb_len),
        .zero (len_zero),
        .last (len_last)
    );

    always_ff @(posedge clk) begin
        if (state_q == HOLD) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end else begin
            hold_cnt <= HOLD_W'(HOLD_CYC);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT_CLR: state_d = IDLE;
            IDLE: begin
                if (trig) begin
                    if (strb_start != '0) begin
                        state_d = DELAY;
                    end else if (strb_len != '0) begin
                        state_d = INTEG;
                    end else begin
                        state_d = WAIT1;
                    end
                end
            end
            DELAY: begin
                if (dly_last || dly_zero) begin
                    state_d = len_zero ? WAIT1 : INTEG;
                end
            end
            INTEG: begin
                if (len_last || len_zero) begin
                    state_d = WAIT1;
                end
            end
            WAIT1: state_d = HOLD;
            HOLD: begin
                if (hold_cnt <= HOLD_W'(1)) begin
                    state_d = CLEAR;
                end
            end
            CLEAR:   state_d = IDLE;
            default: state_d = INIT_CLR;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it;
    // the init clear fires on the cycle leaving INIT_CLR.
    always_comb begin
        bs_d   = (state_d == INTEG);
        iv_d   = (state_d == HOLD);
        busy_d = (state_d != IDLE) && (state_d != INIT_CLR);
        dac_d  = (state_d == CLEAR) || (state_q == INIT_CLR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INIT_CLR;
            sel        <= 2'b00;
            bunch_strb <= 1'b0;
            dac_cond   <= 1'b0;
            int_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bunch_strb <= bs_d;
            dac_cond   <= dac_d;
            int_valid  <= iv_d;
            busy       <= busy_d;
            if (accept) begin
                sel <= sel_in;
            end
        end
    end

`ifdef BUNCH_STRB_SEQ_MISS_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            missed_trig <= '0;
        end else if (accept && (sel_in == 2'b11)) begin
            missed_trig <= '0;
        end else if (trig && (state_q != IDLE) && (missed_trig != '1)) begin
            missed_trig <= missed_trig + MISS_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bunch_strb_seq.sv
// Scoreboard bench for bunch_strb_seq: stimulus pushes expected per-cycle outputs, a monitor compares.
module tb_bunch_strb_seq;

    localparam int DLY_W = 8;
    localparam int LEN_W = 7;
    localparam int HOLD  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             trig;
    logic [DLY_W-1:0] strb_start;
    logic [LEN_W-1:0] strb_len;
    logic [1:0]       sel_in;
    logic [1:0]       sel;
    logic             bunch_strb;
    logic             dac_cond;
    logic             int_valid;
    logic             busy;
`ifdef BUNCH_STRB_SEQ_MISS_CNT_EN
    logic [15:0]      missed_trig;
`endif

    bunch_strb_seq #(.DLY_W(DLY_W), .LEN_W(LEN_W), .HOLD_CYC(HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig       (trig),
        .strb_start (strb_start),
        .strb_len   (strb_len),
        .sel_in     (sel_in),
        .sel        (sel),
        .bunch_strb (bunch_strb),
        .dac_cond   (dac_cond),
        .int_valid  (int_valid),
        .busy       (busy)
`ifdef BUNCH_STRB_SEQ_MISS_CNT_EN
        ,
        .missed_trig(missed_trig)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  sel;
        logic        bs;
        logic        dac;
        logic        iv;
        logic        busy;
        logic        chk_miss;
        logic [15:0] miss;
        logic [7:0]  sid;
        logic [9:0]  cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         strb_cnt = 0;
    logic [1:0] prev_sel = 2'b00;

    task automatic push(input int sid, input int cyc, input logic [1:0] s, input logic bs,
                        input logic dac, input logic iv, input logic bz, input logic chkm,
                        input int miss);
        exp_t e;
        e.sel = s; e.bs = bs; e.dac = dac; e.iv = iv; e.busy = bz;
        e.chk_miss = chkm; e.miss = 16'(miss); e.sid = 8'(sid); e.cyc = 10'(cyc);
        exp_q.push_back(e);
    endtask

    // Monitor: compares one expected entry per cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        total++;
        if (bunch_strb === 1'b1 && dac_cond === 1'b1) begin
            bad++;
            $display("FAIL excl t=%0t bunch_strb and dac_cond both 1, required never both", $time);
        end
        if (bunch_strb === 1'b1) strb_cnt++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({sel, bunch_strb, dac_cond, int_valid, busy} !== {e.sel, e.bs, e.dac, e.iv, e.busy}) begin
                bad++;
                $display("FAIL outs s%0d c%0d got sel=%0d bs=%b dac=%b iv=%b busy=%b required sel=%0d bs=%b dac=%b iv=%b busy=%b",
                         e.sid, e.cyc, sel, bunch_strb, dac_cond, int_valid, busy,
                         e.sel, e.bs, e.dac, e.iv, e.busy);
            end
`ifdef BUNCH_STRB_SEQ_MISS_CNT_EN
            if (e.chk_miss) begin
                total++;
                if (missed_trig !== e.miss) begin
                    bad++;
                    $display("FAIL missed_trig s%0d c%0d got %0d required %0d", e.sid, e.cyc, missed_trig, e.miss);
                end
            end
`endif
        end
    end

    // Runs one triggered sequence; expectations come from the cycle formulas of the timing description.
    task automatic run_seq(input int sid, input int st, input int ln, input logic [1:0] s,
                           input int rt0, input int rt1, input int rt2, input int abort_at,
                           input logic chkm, input int miss);
        int last;
        logic bs, iv, dac, bz;
        last = st + ln + HOLD + 2;
        for (int c = 0; c <= last + 1; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                trig = 1'b1; strb_start = DLY_W'(st); strb_len = LEN_W'(ln); sel_in = s;
                push(sid, c, prev_sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            end else begin
                trig = (c == rt0) || (c == rt1) || (c == rt2);
                strb_start = DLY_W'($urandom); strb_len = LEN_W'($urandom); sel_in = ~s;
                bs  = (c >= st + 1) && (c <= st + ln);
                iv  = (c >= st + ln + 2) && (c <= st + ln + 1 + HOLD);
                dac = (c == last);
                bz  = (c <= last);
                if (c == abort_at) rst_n = 1'b0;
                push(sid, c, s, bs, dac, iv, bz, chkm && (c == last + 1), miss);
                if (c == abort_at) break;
            end
        end
        trig = 1'b0;
        prev_sel = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; trig = 1'b0; strb_start = '0; strb_len = '0; sel_in = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst_n = 1'b1;
            push(0, i, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        end
        @(posedge clk); #1; push(0, 3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk); #1; push(0, 4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk); #1; push(0, 5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        run_seq(1, 3, 5, 2'd2, -1, -1, -1, -1, 1'b0, 0);
        run_seq(2, 0, 0, 2'd1, -1, -1, -1, -1, 1'b0, 0);
        run_seq(3, 3, 5, 2'd3, 2, 6, 14, -1, 1'b1, 3);
        run_seq(4, 0, 4, 2'd1, -1, -1, -1, -1, 1'b0, 0);
        run_seq(5, 2, 0, 2'd2, -1, -1, -1, -1, 1'b0, 0);

        @(posedge clk); #1; push(6, 999, prev_sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        strb_cnt = 0;
        run_seq(6, 255, 127, 2'd0, -1, -1, -1, -1, 1'b0, 0);
        @(negedge clk); #1;
        total++;
        if (strb_cnt != 127) begin
            bad++;
            $display("FAIL strb_count got %0d required 127", strb_cnt);
        end

        // Reset asserted in cycle 6 of a 3/5 sequence, released in cycle 8.
        run_seq(7, 3, 5, 2'd1, -1, -1, -1, 6, 1'b0, 0);
        @(posedge clk); #1; trig = 1'b0;
        push(7, 7, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        push(7, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        push(7, 9, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        prev_sel = 2'b00;
        run_seq(8, 1, 2, 2'd3, -1, -1, -1, -1, 1'b1, 0);

        @(negedge clk); #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got %0d entries left required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bunch_strb_seq.md
Name: bunch_strb_seq

Overview:
- Timing initiator for the BPM I/Q mux/integrator stage.
- Converts a per-pulse trigger into three outputs: the bunch_strb integration window, a mux select held constant for the pulse, and the dac_cond clear pulse.
- Flags (int_valid) the interval during which the downstream integrated sums are stable for DAC/readout sampling.
- Sits between trigger/timing logic and the integrator; one instance drives all four I/Q integrators.

Parameters:
- DLY_W, 8, width of strb_start (trigger-to-window delay, cycles)
- LEN_W, 7, width of strb_len (window length, cycles)
- HOLD_CYC, 4, cycles int_valid is held before dac_cond clears the integrators (≥1)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- trig  in  1  pulse trigger, level sampled each cycle
- strb_start  in  DLY_W  delay from trigger to first strobe cycle
- strb_len  in  LEN_W  number of strobe cycles
- sel_in  in  2  requested mux select
- sel  out  2  select to integrator mux, latched at trigger
- bunch_strb  out  1  integration enable
- dac_cond  out  1  one-cycle integrator clear
- int_valid  out  1  integrated sums stable
- busy  out  1  sequence in progress

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n).
- All outputs are registered. While rst_n=0, all outputs are 0 and the FSM is in INIT_CLR.
- States: INIT_CLR, IDLE, DELAY, INTEG, WAIT1, HOLD, CLEAR.
- INIT_CLR: entered from reset. On the first cycle after rst_n rises, dac_cond=1 for exactly 1 cycle, then IDLE. This clears integrator state, which is not itself reset.
- IDLE, trig=1:
  - Latch sel_in→sel, strb_start and strb_len into internal counters.
  - busy=1 from the next cycle.
  - Next state is DELAY if strb_start>0, else INTEG; if strb_len=0 as well, go straight to WAIT1.
- Timing, with trig sampled in cycle 0:
  - bunch_strb high in cycles strb_start+1 … strb_start+strb_len.
  - WAIT1 is 1 cycle, covering the integrator's output register.
  - int_valid high for HOLD_CYC cycles, starting at cycle strb_start+strb_len+2.
  - CLEAR: dac_cond=1 for exactly 1 cycle, bunch_strb=0. Then IDLE with busy=0.
- strb_len=0: no strobe cycles. int_valid still asserted; the sums are the previous clear value, i.e. 0.
- Max values (strb_start=2^DLY_W−1, strb_len=2^LEN_W−1): no counter wrap. Counters are DLY_W/LEN_W wide and count down to 0.
- bunch_strb and dac_cond are never both 1. The integrator gives strobe priority, so a clear must never coincide with a strobe.
- sel changes only in IDLE on trig. It is held for the entire busy period.
- trig while busy=1: ignored, no effect on timing.
- trig in the same cycle the FSM is in CLEAR: ignored. trig is accepted only in IDLE.
- strb_start/strb_len/sel_in changes while busy: no effect until the next accepted trigger.
- Reset mid-sequence: immediate abort. On the next cycle after release, the INIT_CLR dac_cond pulse discards the partial sum.

Optional Feature:
- Macro BUNCH_STRB_SEQ_MISS_CNT_EN.
- Defined:
  - Adds output port missed_trig (16 bits, saturating at 16'hFFFF), counting trig=1 cycles that arrive while not in IDLE.
  - Resets to 0. Also cleared when trig is accepted in IDLE with sel_in=2'b11.
- Undefined: the port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package bunch_strb_seq_pkg holds:
  - the state enum (7 states, 3-bit encoding)
  - default widths DLY_W/LEN_W
  - the MISS_CNT_W=16 constant
- One sub-module, bss_dncnt: a loadable down-counter (load, enable, width parameter, zero flag). It is instantiated twice, for delay and for length.

Test Plan:
- Reset release → dac_cond=1 for exactly one cycle, then idle with all outputs 0.
- trig in cycle 0, strb_start=3, strb_len=5, HOLD_CYC=4, sel_in=2 → sel=2 from cycle 1; bunch_strb in cycles 4–8; int_valid in cycles 10–13; dac_cond in cycle 14; busy=0 from cycle 15.
- strb_start=0, strb_len=0 → no bunch_strb; int_valid in cycles 2–5; dac_cond in cycle 6.
- Retrigger at cycles 2, 6 and 14 during the sequence above → timing unchanged. With the macro defined, missed_trig=3.
- rst_n low at cycle 6 of the 3/5 sequence, high at cycle 8 → all outputs 0 in cycles 7–8, dac_cond pulse in cycle 9, and a trig in cycle 10 starts a fresh sequence.
- strb_start=255, strb_len=127, plus a checker over all random runs → exactly 127 strobe cycles, and bunch_strb&dac_cond never asserted.
